// File: rtl/dom_sbox_pkg.sv
// rtl/dom_sbox_pkg.sv - constants, packing helpers and golden model for the DOM-masked Ascon S-box array
package dom_sbox_pkg;

    localparam int ASCON_SBOX_W = 5;

    function automatic int rnd_per_and(input int shares);
        return shares * (shares - 1) / 2;
    endfunction

    // Position of the fresh-randomness bit shared by share pair (i, j), i < j.
    function automatic int pair_idx(input int shares, input int i, input int j);
        return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    function automatic int share_bit(input int lanes, input int s, input int l, input int b);
        return (s * lanes + l) * ASCON_SBOX_W + b;
    endfunction

    function automatic logic [4:0] sbox_ref(input logic [4:0] x);
        logic x0, x1, x2, x3, x4;
        logic t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = x;
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

endpackage

// File: rtl/dom_and_nshare.sv
// rtl/dom_and_nshare.sv - one registered DOM-indep AND gate over SHARES Boolean shares
module dom_and_nshare
    import dom_sbox_pkg::*;
#(
    parameter int SHARES = 2,
    localparam int RPA = rnd_per_and(SHARES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [SHARES-1:0] a,
    input  logic [SHARES-1:0] b,
    input  logic [RPA-1:0]    z,
    output logic [SHARES-1:0] q
);

    // Row i of the term matrix holds every product feeding output share i.
    logic [SHARES*SHARES-1:0] term_d;
    logic [SHARES*SHARES-1:0] term_q;

    for (genvar i = 0; i < SHARES; i++) begin : g_row
        for (genvar j = 0; j < SHARES; j++) begin : g_col
            if (i == j) begin : g_inner
                assign term_d[i*SHARES+j] = a[i] & b[j];
            end else begin : g_cross
                localparam int P = (i < j) ? pair_idx(SHARES, i, j) : pair_idx(SHARES, j, i);
                assign term_d[i*SHARES+j] = (a[i] & b[j]) ^ z[P];
            end
        end
        assign q[i] = ^term_q[i*SHARES +: SHARES];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            term_q <= '0;
        end else if (en) begin
            term_q <= term_d;
        end
    end

endmodule

// File: rtl/dom_ascon_sbox_pipe.sv
// rtl/dom_ascon_sbox_pipe.sv - LANES parallel DOM-masked Ascon S-boxes with valid/ready stall; DOM_SBOX_OUTREG_EN adds an output register stage
module dom_ascon_sbox_pipe
    import dom_sbox_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int LANES  = 1,
    localparam int RPA = rnd_per_and(SHARES),
    localparam int W   = SHARES * LANES * ASCON_SBOX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             x_sh,
    input  logic                     rnd_valid,
    input  logic [LANES*5*RPA-1:0]   z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             y_sh
);

    logic         accept;
    logic [W-1:0] pre;
    logic [W-1:0] pre_q;
    logic [W-1:0] t;
    logic [W-1:0] y_comb;

    assign accept = in_valid & rnd_valid & in_ready;

    // AND k computes t_k = ~x_k & x_{k+1}; x_k sits at bit 4-k.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar k = 0; k < 5; k++) begin : g_and
            logic [SHARES-1:0] a;
            logic [SHARES-1:0] b;
            logic [SHARES-1:0] q;
            for (genvar s = 0; s < SHARES; s++) begin : g_sh
                assign a[s] = pre[share_bit(LANES, s, l, 4 - k)] ^ ((s == 0) ? 1'b1 : 1'b0);
                assign b[s] = pre[share_bit(LANES, s, l, 4 - ((k + 1) % 5))];
                assign t[share_bit(LANES, s, l, 4 - k)] = q[s];
            end
            dom_and_nshare #(.SHARES(SHARES)) u_and (
                .clk (clk),
                .rst (rst),
                .en  (accept),
                .a   (a),
                .b   (b),
                .z   (z[(l*5+k)*RPA +: RPA]),
                .q   (q)
            );
        end

        for (genvar s = 0; s < SHARES; s++) begin : g_lin
            localparam int B = share_bit(LANES, s, l, 0);
            localparam logic INV = (s == 0) ? 1'b1 : 1'b0;
            logic [4:0] v;
            logic [4:0] pq;
            logic [4:0] tt;
            logic [4:0] c;
            assign v  = x_sh[B +: 5];
            assign pq = pre_q[B +: 5];
            assign tt = t[B +: 5];

            assign pre[B+4] = v[4] ^ v[0];
            assign pre[B+3] = v[3];
            assign pre[B+2] = v[2] ^ v[3];
            assign pre[B+1] = v[1];
            assign pre[B+0] = v[0] ^ v[1];

            assign c[4] = pq[4] ^ tt[3];
            assign c[3] = pq[3] ^ tt[2];
            assign c[2] = pq[2] ^ tt[1];
            assign c[1] = pq[1] ^ tt[0];
            assign c[0] = pq[0] ^ tt[4];

            assign y_comb[B+4] = c[4] ^ c[0];
            assign y_comb[B+3] = c[3] ^ c[4];
            assign y_comb[B+2] = c[2] ^ INV;
            assign y_comb[B+1] = c[1] ^ c[2];
            assign y_comb[B+0] = c[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else if (accept) begin
            pre_q <= pre;
        end
    end

`ifdef DOM_SBOX_OUTREG_EN
    logic         v1;
    logic         v2;
    logic         adv2;
    logic [W-1:0] y_q;

    assign adv2     = !v2 | out_ready;
    assign in_ready = !(v1 & v2 & !out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            y_q <= '0;
        end else begin
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    y_q <= y_comb;
                end
            end
            if (accept) begin
                v1 <= 1'b1;
            end else if (adv2) begin
                v1 <= 1'b0;
            end
        end
    end

    assign out_valid = v2;
    assign y_sh      = y_q;
`else
    logic v1;

    assign in_ready = !v1 | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (accept) begin
            v1 <= 1'b1;
        end else if (out_ready) begin
            v1 <= 1'b0;
        end
    end

    // Share-0 complement would otherwise leak a constant onto an idle output.
    assign out_valid = v1;
    assign y_sh      = {W{v1}} & y_comb;
`endif

endmodule

// File: tb/tb_dom_ascon_sbox_pipe.sv
// tb/tb_dom_ascon_sbox_pipe.sv - self-checking bench for dom_ascon_sbox_pipe (2-share single lane and 3-share 64-lane)
module tb_dom_ascon_sbox_pipe;

    localparam int LB = 64;
    localparam int SB = 3;
    localparam int WB = SB * LB * 5;
    localparam int ZB = LB * 5 * 3;
    localparam int NB = 150;
`ifdef DOM_SBOX_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [4:0] x;
        logic [4:0] y;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        va, rva, irdy_a, ov_a, ordy_a;
    logic [9:0]  xa, ya;
    logic [4:0]  za;

    logic          vb, rvb, irdy_b, ov_b, ordy_b;
    logic [WB-1:0] xb, yb;
    logic [ZB-1:0] zb;

    int n_cmp = 0;
    int n_fail = 0;
    logic [4:0]      qa[$];
    logic [LB*5-1:0] qb[$];
    logic [4:0]      tbl[32];
    vec_t            vecs[32];
    logic [9:0]      last_ya;
    bit              done_b;

    dom_ascon_sbox_pipe #(.SHARES(2), .LANES(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(irdy_a), .x_sh(xa),
        .rnd_valid(rva), .z(za), .out_valid(ov_a), .out_ready(ordy_a), .y_sh(ya)
    );

    dom_ascon_sbox_pipe #(.SHARES(SB), .LANES(LB)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(irdy_b), .x_sh(xb),
        .rnd_valid(rvb), .z(zb), .out_valid(ov_b), .out_ready(ordy_b), .y_sh(yb)
    );

    task automatic check(input string name, input logic [LB*5-1:0] act, input logic [LB*5-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting, got no event expected one", name);
    endtask

    function automatic logic [LB*5-1:0] rand320();
        logic [LB*5-1:0] r;
        for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [ZB-1:0] rand960();
        logic [ZB-1:0] r;
        for (int k = 0; k < 30; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [LB*5-1:0] recomb_b(input logic [WB-1:0] y);
        logic [LB*5-1:0] r;
        r = '0;
        for (int l = 0; l < LB; l++)
            for (int s = 0; s < SB; s++)
                r[l*5 +: 5] ^= y[(s*LB+l)*5 +: 5];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && ov_a && ordy_a) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_extra: got output %0h expected none", ya);
            end else begin
                check("a_sbox", ya[4:0] ^ ya[9:5], qa.pop_front());
            end
            last_ya <= ya;
        end
        if (!rst && ov_b && ordy_b) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_extra: got an output expected none");
            end else begin
                check("b_stream", recomb_b(yb), qb.pop_front());
            end
        end
    end

    task automatic send_a(input logic [4:0] x, input logic [4:0] exp, input logic [4:0] m, input logic [4:0] zz);
        bit acc;
        acc = 0;
        xa = {x ^ m, m};
        za = zz;
        va = 1'b1;
        rva = 1'b1;
        for (int c = 0; c < 40 && !acc; c++) begin
            @(negedge clk);
            if (irdy_a) begin
                qa.push_back(exp);
                acc = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!acc) timeout("send_a");
        @(posedge clk); #1;
        va = 1'b0;
    endtask

    task automatic drain_a();
        for (int c = 0; c < 50 && qa.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        if (qa.size() != 0) timeout("drain_a");
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]      ystall;
        logic [9:0]      yz0;
        int              lat;
        logic [LB*5-1:0] xv, ev, m1, m2;

        tbl = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
        for (int i = 0; i < 32; i++) begin
            vecs[i].x = 5'(i);
            vecs[i].y = tbl[i];
        end

        rst = 1'b1;
        va = 0; rva = 0; xa = '0; za = '0; ordy_a = 1'b1;
        vb = 0; rvb = 0; xb = '0; zb = '0; ordy_b = 1'b1;
        done_b = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ov_a", ov_a, 0);
        check("reset_y_a", ya, 0);
        check("reset_ready_a", irdy_a, 1);
        check("reset_ov_b", ov_b, 0);
        check("reset_y_b", recomb_b(yb) | yb[LB*5-1:0], 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // exhaustive table, back-to-back, random masks and randomness
        for (int i = 0; i < 32; i++)
            send_a(vecs[i].x, vecs[i].y, 5'($urandom), 5'($urandom));
        drain_a();

        // randomness changes shares but not the recombined value
        send_a(5'h0D, tbl[13], 5'h0A, 5'h00);
        drain_a();
        yz0 = last_ya;
        send_a(5'h0D, tbl[13], 5'h0A, 5'h1F);
        drain_a();
        n_cmp++;
        if (last_ya === yz0) begin
            n_fail++;
            $display("FAIL z_share_diff: got shares %0h expected different from %0h", last_ya, yz0);
        end

        // no accept without fresh randomness
        xa = {5'h10 ^ 5'h07, 5'h07};
        za = 5'($urandom);
        va = 1'b1;
        rva = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rv_hold_ov", ov_a, 0);
            check("rv_ready", irdy_a, 1);
            @(posedge clk); #1;
        end
        send_a(5'h10, 5'h1E, 5'h07, 5'($urandom));
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lat++;
            if (ov_a) break;
            @(posedge clk); #1;
        end
        check("latency", lat, LAT);
        drain_a();

        // backpressure: fill the pipe, stall 5 cycles while z wiggles
        ordy_a = 1'b0;
        for (int p = 0; p < LAT; p++)
            send_a(5'(p + 2), tbl[p+2], 5'($urandom), 5'($urandom));
        xa = {5'h1F ^ 5'h15, 5'h15};
        za = 5'($urandom);
        va = 1'b1;
        rva = 1'b1;
        @(negedge clk);
        ystall = ya;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            za = 5'($urandom);
            @(negedge clk);
            check("bp_valid", ov_a, 1);
            check("bp_ready", irdy_a, 0);
            check("bp_y_stable", ya, ystall);
        end
        @(posedge clk); #1;
        ordy_a = 1'b1;
        @(negedge clk);
        check("bp_release_ready", irdy_a, 1);
        qa.push_back(5'h17);
        @(posedge clk); #1;
        va = 1'b0;
        @(negedge clk);
        check("bp_back_to_back", ov_a, 1);
        drain_a();

        // reset one cycle after accept discards the in-flight result
        ordy_a = 1'b0;
        send_a(5'h05, tbl[5], 5'($urandom), 5'($urandom));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ov", ov_a, 0);
        check("rst_mid_y", ya, 0);
        qa.delete();
        @(posedge clk); #1;
        ordy_a = 1'b1;
        send_a(5'h01, 5'h0B, 5'($urandom), 5'($urandom));
        drain_a();

        // 3-share 64-lane random streaming with random backpressure
        fork
            begin
                for (int n = 0; n < NB; n++) begin
                    bit acc;
                    for (int l = 0; l < LB; l++) begin
                        xv[l*5 +: 5] = 5'($urandom);
                        ev[l*5 +: 5] = tbl[xv[l*5 +: 5]];
                    end
                    m1 = rand320();
                    m2 = rand320();
                    for (int l = 0; l < LB; l++) begin
                        xb[(0*LB+l)*5 +: 5] = xv[l*5 +: 5] ^ m1[l*5 +: 5] ^ m2[l*5 +: 5];
                        xb[(1*LB+l)*5 +: 5] = m1[l*5 +: 5];
                        xb[(2*LB+l)*5 +: 5] = m2[l*5 +: 5];
                    end
                    zb = rand960();
                    rvb = ($urandom_range(0, 3) != 0);
                    vb = 1'b1;
                    acc = 0;
                    for (int c = 0; c < 200 && !acc; c++) begin
                        @(negedge clk);
                        if (irdy_b && rvb) begin
                            qb.push_back(ev);
                            acc = 1;
                        end
                        @(posedge clk); #1;
                        if (!acc) begin
                            rvb = ($urandom_range(0, 3) != 0);
                            zb = rand960();
                        end
                    end
                    if (!acc) timeout("send_b");
                    vb = 1'b0;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done_b = 1;
            end
            begin
                while (!done_b) begin
                    @(posedge clk); #1;
                    ordy_b = ($urandom_range(0, 2) != 0);
                end
            end
        join
        ordy_b = 1'b1;
        for (int c = 0; c < 50 && qb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        if (qb.size() != 0) timeout("drain_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
